// File: rtl/mmap_kron_pkg.sv
// Shared types for the boolean-quadtree Kronecker product core:
// input token and result node layouts, tag encodings and FSM states.
package mmap_kron_pkg;

    localparam int PTR_W = 16;

    localparam logic [1:0] QNONE  = 2'd0;
    localparam logic [1:0] QVAL   = 2'd1;
    localparam logic [1:0] QNODE  = 2'd2;
    localparam logic [1:0] QERROR = 2'd3;

    typedef struct packed {
        logic [1:0]       tag;
        logic [PTR_W-1:0] c0;
        logic [PTR_W-1:0] c1;
        logic [PTR_W-1:0] c2;
        logic [PTR_W-1:0] c3;
        logic             val;
    } qtree_bool_t;

    typedef struct packed {
        logic [1:0]       tag;
        logic [PTR_W-1:0] p0;
        logic [PTR_W-1:0] p1;
        logic [PTR_W-1:0] p2;
        logic [PTR_W-1:0] p3;
        logic [31:0]      value;
    } qtree_nat_t;

    typedef struct packed {
        logic [PTR_W-1:0] ptr;
        logic             valid;
    } pointer_qtree_nat_t;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        MAP_B,
        WALK_A,
        DONE
    } state_t;

endpackage

// File: rtl/mmap_kron_heap.sv
// Result heap: simple dual-port RAM, one synchronous write port and one
// registered read port.
module mmap_kron_heap #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 98,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: RAM contents are never reset; every entry the result references is written before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mmap_kron_wrapper.sv
// Streaming mMapKron: loads quadtrees A and B, maps B into the heap, then
// walks A post-order substituting every true leaf with the shared B root.
module mmap_kron_wrapper
    import mmap_kron_pkg::*;
#(
    parameter int IN_DEPTH  = 1024,
    parameter int OUT_DEPTH = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [66:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    input  logic        o_tready,
    output logic [16:0] o_tdata
);

    localparam int IA_W = $clog2(IN_DEPTH);
    localparam int HA_W = $clog2(OUT_DEPTH);
    localparam logic [PTR_W-1:0] IN_MAX   = PTR_W'(IN_DEPTH);
    localparam logic [PTR_W-1:0] HEAP_MAX = PTR_W'(OUT_DEPTH);

    state_t             state;
    logic [PTR_W-1:0]   n_a, n_b, idx, wp;
    logic [PTR_W-1:0]   last_a, last_b;
    pointer_qtree_nat_t out_q;

    qtree_bool_t        buf_a [IN_DEPTH];
    qtree_bool_t        buf_b [IN_DEPTH];
    logic [PTR_W-1:0]   r_tab [IN_DEPTH];

    qtree_bool_t        tok_a, tok_b;
    logic               hs, child_bad, advance_wp;
    logic [PTR_W-1:0]   r_next;
    logic               heap_we;
    logic [HA_W-1:0]    heap_waddr;
    qtree_nat_t         heap_wdata;
    qtree_nat_t         unused_heap_rd;
    logic               unused_o_tready;

    // The result is held until reset, so the sink handshake has no effect.
    assign unused_o_tready = o_tready;

    assign i_tready = !aresetn && (state == LOAD_A || state == LOAD_B);
    assign hs       = i_tvalid && i_tready;
    assign o_tdata  = out_q;
    assign last_a   = n_a - PTR_W'(1);
    assign last_b   = n_b - PTR_W'(1);
    assign tok_a    = buf_a[idx[IA_W-1:0]];
    assign tok_b    = buf_b[idx[IA_W-1:0]];

    // Post-order guarantees children precede parents; anything else is malformed.
    assign child_bad = (tok_a.c0 >= idx) || (tok_a.c1 >= idx) ||
                       (tok_a.c2 >= idx) || (tok_a.c3 >= idx);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        heap_we    = 1'b0;
        heap_waddr = wp[HA_W-1:0];
        heap_wdata = '0;
        r_next     = wp;
        advance_wp = 1'b0;
        case (state)
            MAP_B: begin
                heap_we        = idx < HEAP_MAX;
                heap_waddr     = idx[HA_W-1:0];
                heap_wdata.tag = tok_b.tag;
                if (tok_b.tag == QVAL) begin
                    heap_wdata.value = {31'b0, tok_b.val};
                end else if (tok_b.tag == QNODE) begin
                    heap_wdata.p0 = tok_b.c0;
                    heap_wdata.p1 = tok_b.c1;
                    heap_wdata.p2 = tok_b.c2;
                    heap_wdata.p3 = tok_b.c3;
                end
            end
            WALK_A: begin
                if (tok_a.tag == QVAL && tok_a.val) begin
                    r_next = last_b;
                end else begin
                    advance_wp     = 1'b1;
                    heap_we        = wp < HEAP_MAX;
                    heap_wdata.tag = (tok_a.tag == QVAL) ? QNONE : tok_a.tag;
                    if (tok_a.tag == QNODE) begin
                        if (child_bad) begin
                            heap_wdata.tag = QERROR;
                        end else begin
                            heap_wdata.p0 = r_tab[tok_a.c0[IA_W-1:0]];
                            heap_wdata.p1 = r_tab[tok_a.c1[IA_W-1:0]];
                            heap_wdata.p2 = r_tab[tok_a.c2[IA_W-1:0]];
                            heap_wdata.p3 = r_tab[tok_a.c3[IA_W-1:0]];
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Token buffers and the r[] table hold no state of their own: the counts gate every read.
    always_ff @(posedge aclk) begin
        if (hs && state == LOAD_A && n_a < IN_MAX) begin
            buf_a[n_a[IA_W-1:0]] <= i_tdata;
        end
        if (hs && state == LOAD_B && n_b < IN_MAX) begin
            buf_b[n_b[IA_W-1:0]] <= i_tdata;
        end
        if (!aresetn && state == WALK_A) begin
            r_tab[idx[IA_W-1:0]] <= r_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            state <= LOAD_A;
            n_a   <= '0;
            n_b   <= '0;
            idx   <= '0;
            wp    <= '0;
            out_q <= '0;
        end else begin
            case (state)
                LOAD_A: if (hs) begin
                    if (n_a < IN_MAX) n_a <= n_a + PTR_W'(1);
                    if (i_tlast) state <= LOAD_B;
                end
                LOAD_B: if (hs) begin
                    if (n_b < IN_MAX) n_b <= n_b + PTR_W'(1);
                    if (i_tlast) begin
                        state <= MAP_B;
                        idx   <= '0;
                    end
                end
                MAP_B: begin
                    if (idx == last_b) begin
                        state <= WALK_A;
                        idx   <= '0;
                        wp    <= n_b;
                    end else begin
                        idx <= idx + PTR_W'(1);
                    end
                end
                WALK_A: begin
                    if (advance_wp) wp <= wp + PTR_W'(1);
                    if (idx == last_a) state <= DONE;
                    else               idx   <= idx + PTR_W'(1);
                end
                DONE: begin
                    out_q.ptr   <= r_tab[last_a[IA_W-1:0]];
                    out_q.valid <= 1'b1;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    mmap_kron_heap #(
        .DEPTH (OUT_DEPTH),
        .WIDTH ($bits(qtree_nat_t))
    ) u_heap (
        .clk   (aclk),
        .we    (heap_we),
        .waddr (heap_waddr),
        .wdata (heap_wdata),
        .raddr ('0),
        .rdata (unused_heap_rd)
    );

endmodule

// File: tb/tb_mmap_kron_wrapper.sv
// Directed bench for mmap_kron_wrapper: hand-computed heap contents, root
// pointers and latencies for small A/B quadtree pairs.
module tb_mmap_kron_wrapper;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [66:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic        o_tready = 1'b1;
    logic [16:0] o_tdata;

    int n_cmp = 0;
    int n_bad = 0;

    mmap_kron_wrapper dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tready (o_tready),
        .o_tdata  (o_tdata)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [66:0] t_none();
        return {2'd0, 65'd0};
    endfunction
    function automatic logic [66:0] t_val(input logic v);
        return {2'd1, 64'd0, v};
    endfunction
    function automatic logic [66:0] t_node(input int c0, input int c1, input int c2, input int c3);
        return {2'd2, 16'(c0), 16'(c1), 16'(c2), 16'(c3), 1'b0};
    endfunction
    function automatic logic [66:0] t_err();
        return {2'd3, 65'd0};
    endfunction
    function automatic logic [97:0] nat(input logic [1:0] tag, input int p0, input int p1,
                                        input int p2, input int p3, input int value);
        return {tag, 16'(p0), 16'(p1), 16'(p2), 16'(p3), 32'(value)};
    endfunction

    task automatic send(input logic [66:0] d, input logic last);
        int guard = 0;
        @(negedge aclk);
        i_tdata  = d;
        i_tlast  = last;
        i_tvalid = 1'b1;
        while (!i_tready && guard < 50) begin
            @(negedge aclk);
            guard++;
        end
        if (guard >= 50) begin
            $display("FAIL send_ready: i_tready stayed %b, expected 1", i_tready);
            n_bad++;
        end
        @(posedge aclk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        aresetn = 1'b0;
    endtask

    // Streams A then B; returns cycles from the final B handshake to a valid result.
    task automatic run_tree(input logic [66:0] a[$], input logic [66:0] b[$],
                            input bit gaps, output int lat);
        foreach (a[k]) begin
            send(a[k], k == a.size() - 1);
            if (gaps) @(negedge aclk);
        end
        foreach (b[k]) begin
            send(b[k], k == b.size() - 1);
            if (gaps && k != b.size() - 1) @(negedge aclk);
        end
        lat = 0;
        while (lat < 300) begin
            @(negedge aclk);
            if (o_tdata[0] === 1'b1) break;
            lat++;
        end
    endtask

    task automatic check_heap(input string name, input int addr, input logic [97:0] exp);
        logic [97:0] got;
        got = dut.u_heap.mem[addr];
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL %s heap[%0d]: got %h, expected %h", name, addr, got, exp);
            n_bad++;
        end
    endtask

    task automatic check_out(input string name, input int lat, input int exp_lat,
                             input logic [16:0] exp);
        n_cmp++;
        if (lat !== exp_lat) begin
            $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
            n_bad++;
        end
        n_cmp++;
        if (o_tdata !== exp) begin
            $display("FAIL %s o_tdata: got %h, expected %h", name, o_tdata, exp);
            n_bad++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        n_cmp++;
        if (o_tdata !== 17'h0 || i_tready !== 1'b0) begin
            $display("FAIL reset_outputs: got o_tdata=%h i_tready=%b, expected 0/0", o_tdata, i_tready);
            n_bad++;
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (i_tready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b, expected 1", i_tready);
            n_bad++;
        end
    endtask

    task automatic test_single();
        logic [66:0] qa[$];
        logic [66:0] qb[$];
        int lat;
        qa = '{t_val(1'b1)};
        qb = '{t_val(1'b1)};
        run_tree(qa, qb, 1'b0, lat);
        check_out("single", lat, 3, 17'h00001);
        check_heap("single", 0, nat(2'd1, 0, 0, 0, 0, 1));
        repeat (5) @(negedge aclk);
        n_cmp++;
        if (o_tdata !== 17'h00001 || i_tready !== 1'b0) begin
            $display("FAIL done_hold: got o_tdata=%h i_tready=%b, expected 00001/0", o_tdata, i_tready);
            n_bad++;
        end
    endtask

    task automatic test_val0();
        logic [66:0] qa[$];
        logic [66:0] qb[$];
        int lat;
        do_reset();
        qa = '{t_val(1'b0)};
        qb = '{t_val(1'b1)};
        run_tree(qa, qb, 1'b0, lat);
        check_out("val0", lat, 3, 17'h00003);
        check_heap("val0", 1, nat(2'd0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_tree(input bit gaps);
        logic [66:0] qa[$];
        logic [66:0] qb[$];
        int lat;
        string name;
        name = gaps ? "tree_gaps" : "tree";
        do_reset();
        qa = '{t_val(1'b1), t_none(), t_val(1'b0), t_val(1'b1), t_node(0, 1, 2, 3)};
        qb = '{t_val(1'b1)};
        run_tree(qa, qb, gaps, lat);
        check_out(name, lat, 7, 17'h00007);
        check_heap(name, 0, nat(2'd1, 0, 0, 0, 0, 1));
        check_heap(name, 1, nat(2'd0, 0, 0, 0, 0, 0));
        check_heap(name, 2, nat(2'd0, 0, 0, 0, 0, 0));
        check_heap(name, 3, nat(2'd2, 0, 1, 2, 0, 0));
    endtask

    task automatic test_mid_reset();
        logic [66:0] qa[$];
        logic [66:0] qb[$];
        int lat;
        do_reset();
        send(t_err(), 1'b0);
        send(t_val(1'b0), 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if (o_tdata !== 17'h0 || i_tready !== 1'b0) begin
            $display("FAIL mid_reset_outputs: got o_tdata=%h i_tready=%b, expected 0/0", o_tdata, i_tready);
            n_bad++;
        end
        aresetn = 1'b0;
        qa = '{t_val(1'b1), t_none(), t_val(1'b0), t_val(1'b1), t_node(0, 1, 2, 3)};
        qb = '{t_val(1'b1)};
        run_tree(qa, qb, 1'b0, lat);
        check_out("mid_reset", lat, 7, 17'h00007);
        check_heap("mid_reset", 3, nat(2'd2, 0, 1, 2, 0, 0));
    endtask

    task automatic test_bad_child();
        logic [66:0] qa[$];
        logic [66:0] qb[$];
        int lat;
        do_reset();
        qa = '{t_node(0, 0, 0, 0)};
        qb = '{t_val(1'b1)};
        run_tree(qa, qb, 1'b0, lat);
        check_out("bad_child", lat, 3, 17'h00003);
        check_heap("bad_child", 1, nat(2'd3, 0, 0, 0, 0, 0));
    endtask

    // B exercises every tag in MAP_B; A's single true leaf points at B's root.
    task automatic test_map_b();
        logic [66:0] qa[$];
        logic [66:0] qb[$];
        int lat;
        do_reset();
        qa = '{t_val(1'b1)};
        qb = '{t_val(1'b0), t_val(1'b1), t_none(), t_err(), t_node(0, 1, 2, 3)};
        run_tree(qa, qb, 1'b0, lat);
        check_out("map_b", lat, 7, 17'h00009);
        check_heap("map_b", 0, nat(2'd1, 0, 0, 0, 0, 0));
        check_heap("map_b", 1, nat(2'd1, 0, 0, 0, 0, 1));
        check_heap("map_b", 2, nat(2'd0, 0, 0, 0, 0, 0));
        check_heap("map_b", 3, nat(2'd3, 0, 0, 0, 0, 0));
        check_heap("map_b", 4, nat(2'd2, 0, 1, 2, 3, 0));
    endtask

    task automatic test_a_error();
        logic [66:0] qa[$];
        logic [66:0] qb[$];
        int lat;
        do_reset();
        qa = '{t_err(), t_val(1'b1), t_node(1, 0, 1, 0)};
        qb = '{t_val(1'b0)};
        run_tree(qa, qb, 1'b0, lat);
        check_out("a_error", lat, 5, 17'h00005);
        check_heap("a_error", 1, nat(2'd3, 0, 0, 0, 0, 0));
        check_heap("a_error", 2, nat(2'd2, 0, 1, 0, 1, 0));
    endtask

    initial begin
        test_reset();
        test_single();
        test_val0();
        test_tree(1'b0);
        test_tree(1'b1);
        test_mid_reset();
        test_bad_child();
        test_map_b();
        test_a_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
